// File: rtl/legv8_pkg.sv
// Shared LEGv8 front-end constants: instruction size and PC sequencer state encoding.
package legv8_pkg;

  localparam int unsigned INST_BYTES = 4;
  localparam int unsigned INST_SHIFT = $clog2(INST_BYTES);

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t StBoot  = 2'd0;
  localparam seq_state_t StRun   = 2'd1;
  localparam seq_state_t StFlush = 2'd2;
  localparam seq_state_t StHalt  = 2'd3;

  // True when a byte address sits on an instruction boundary.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/pc_target_adder.sv
// PC-relative branch target: pc + (sign-extended instruction offset scaled to bytes).
module pc_target_adder
  import legv8_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned OFF_W  = 26
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [OFF_W-1:0]  br_offset,
  output logic [ADDR_W-1:0] br_target
);

  // Work wide enough for either operand; the final add truncates to ADDR_W (mod 2^ADDR_W).
  localparam int unsigned ExtW = (ADDR_W > OFF_W + INST_SHIFT) ? ADDR_W : OFF_W + INST_SHIFT;

  logic [ExtW-1:0] off_sext;
  logic [ExtW-1:0] off_bytes;

  assign off_sext  = {{(ExtW - OFF_W){br_offset[OFF_W-1]}}, br_offset};
  assign off_bytes = off_sext << INST_SHIFT;
  assign br_target = pc + off_bytes[ADDR_W-1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: boot bubble, sequential fetch with backpressure, redirects with a
// one-cycle squash bubble, halt, and a sticky misaligned-jump flag.
module pc_sequencer
  import legv8_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       OFF_W     = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              halt,
  input  logic              br_taken,
  input  logic [OFF_W-1:0]  br_offset,
  input  logic              reg_jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              fetch_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_valid,
  output logic              misalign_err
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] jump_pc;

  pc_target_adder #(
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W)
  ) u_target_adder (
    .pc        (pc_q),
    .br_offset (br_offset),
    .br_target (br_target)
  );

  assign jump_pc  = {jump_target[ADDR_W-1:2], 2'b00};
  assign pc_plus4 = pc_q + ADDR_W'(INST_BYTES);

  // Gated by reset so no fetch is requested while reset is held, even before the first edge.
  assign fetch_valid  = !reset && (state_q == StRun) && !stall;
  assign pc           = pc_q;
  assign misalign_err = err_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    unique case (state_q)
      StBoot: begin
        state_d = halt ? StHalt : StRun;
      end
      StRun, StFlush: begin
        if (halt) begin
          state_d = StHalt;
        end else if (reg_jump) begin
          pc_d    = jump_pc;
          state_d = StFlush;
          if (!is_word_aligned(jump_target[1:0])) begin
            err_d = 1'b1;
          end
        end else if (br_taken) begin
          pc_d    = br_target;
          state_d = StFlush;
        end else if (state_q == StFlush) begin
          state_d = StRun;
        end else if (fetch_valid && fetch_ready) begin
          pc_d = pc_plus4;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StBoot;
      pc_q    <= RESET_VEC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a 64-bit instance and an 8-bit instance for wrap tests.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        reset8;
  logic        stall;
  logic        halt;
  logic        br_taken;
  logic [25:0] br_offset;
  logic        reg_jump;
  logic [63:0] jump_target;
  logic [7:0]  jump_target8;
  logic        fetch_ready;

  logic [63:0] pc64, pc_plus4_64;
  logic        fv64, err64;
  logic [7:0]  pc8, pc_plus4_8;
  logic        fv8, err8;

  assign jump_target8 = jump_target[7:0];

  pc_sequencer #(
    .ADDR_W    (64),
    .RESET_VEC (64'd0),
    .OFF_W     (26)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .halt         (halt),
    .br_taken     (br_taken),
    .br_offset    (br_offset),
    .reg_jump     (reg_jump),
    .jump_target  (jump_target),
    .fetch_ready  (fetch_ready),
    .pc           (pc64),
    .pc_plus4     (pc_plus4_64),
    .fetch_valid  (fv64),
    .misalign_err (err64)
  );

  pc_sequencer #(
    .ADDR_W    (8),
    .RESET_VEC (8'hF0),
    .OFF_W     (26)
  ) dut8 (
    .clk          (clk),
    .reset        (reset8),
    .stall        (stall),
    .halt         (halt),
    .br_taken     (br_taken),
    .br_offset    (br_offset),
    .reg_jump     (reg_jump),
    .jump_target  (jump_target8),
    .fetch_ready  (fetch_ready),
    .pc           (pc8),
    .pc_plus4     (pc_plus4_8),
    .fetch_valid  (fv8),
    .misalign_err (err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sel;
    string       name;
    logic [63:0] pc;
    bit          fv;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;
  bit   cur_sel;

  exp_t        m_e;
  logic [63:0] m_pc, m_p4, m_exp_p4;
  logic        m_fv, m_err;

  // Monitor: one expectation per cycle, compared mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      if (m_e.sel) begin
        m_pc     = {56'd0, pc8};
        m_p4     = {56'd0, pc_plus4_8};
        m_fv     = fv8;
        m_err    = err8;
        m_exp_p4 = {56'd0, m_e.pc[7:0] + 8'd4};
      end else begin
        m_pc     = pc64;
        m_p4     = pc_plus4_64;
        m_fv     = fv64;
        m_err    = err64;
        m_exp_p4 = m_e.pc + 64'd4;
      end
      vectors++;
      if (m_pc !== m_e.pc || m_p4 !== m_exp_p4 || m_fv !== m_e.fv || m_err !== m_e.err) begin
        miscompares++;
        $display("FAIL %s: got pc=%h pc_plus4=%h fetch_valid=%b misalign_err=%b, want pc=%h pc_plus4=%h fetch_valid=%b misalign_err=%b",
                 m_e.name, m_pc, m_p4, m_fv, m_err, m_e.pc, m_exp_p4, m_e.fv, m_e.err);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic cyc(input string nm, input bit rs, input bit st, input bit hl, input bit br,
                     input int off, input bit rj, input logic [63:0] jt, input bit rdy,
                     input logic [63:0] epc, input bit efv, input bit eerr);
    exp_t e;
    if (cur_sel) reset8 = rs;
    else         reset  = rs;
    stall       = st;
    halt        = hl;
    br_taken    = br;
    br_offset   = 26'(off);
    reg_jump    = rj;
    jump_target = jt;
    fetch_ready = rdy;
    e.sel  = cur_sel;
    e.name = nm;
    e.pc   = epc;
    e.fv   = efv;
    e.err  = eerr;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cur_sel     = 1'b0;
    reset       = 1'b1;
    reset8      = 1'b1;
    stall       = 1'b0;
    halt        = 1'b0;
    br_taken    = 1'b0;
    br_offset   = '0;
    reg_jump    = 1'b0;
    jump_target = '0;
    fetch_ready = 1'b1;
    @(posedge clk);
    #1;

    //  name          rs st hl br off rj jt        rdy  exp pc    fv err
    cyc("reset",       1, 0, 0, 0,  0, 0, 64'h0,    1,  64'h0,    0, 0);
    cyc("boot",        0, 0, 0, 0,  0, 0, 64'h0,    1,  64'h0,    0, 0);
    cyc("run0",        0, 0, 0, 0,  0, 0, 64'h0,    1,  64'h0,    1, 0);
    cyc("run4",        0, 0, 0, 0,  0, 0, 64'h0,    1,  64'h4,    1, 0);
    cyc("bp8_a",       0, 0, 0, 0,  0, 0, 64'h0,    0,  64'h8,    1, 0);
    cyc("bp8_b",       0, 0, 0, 0,  0, 0, 64'h0,    0,  64'h8,    1, 0);
    cyc("bp8_c",       0, 0, 0, 0,  0, 0, 64'h0,    0,  64'h8,    1, 0);
    cyc("bp8_go",      0, 0, 0, 0,  0, 0, 64'h0,    1,  64'h8,    1, 0);
    cyc("run12",       0, 0, 0, 0,  0, 0, 64'h0,    1,  64'hC,    1, 0);
    cyc("br_at16",     0, 0, 0, 1, -2, 0, 64'h0,    1,  64'h10,   1, 0);
    cyc("br_flush",    0, 0, 0, 0,  0, 0, 64'h0,    1,  64'h8,    0, 0);
    cyc("br_run8",     0, 0, 0, 0,  0, 0, 64'h0,    1,  64'h8,    1, 0);
    cyc("stall12",     0, 1, 0, 0,  0, 0, 64'h0,    1,  64'hC,    0, 0);
    cyc("unstall12",   0, 0, 0, 0,  0, 0, 64'h0,    1,  64'hC,    1, 0);
    cyc("jmp_to0",     0, 0, 0, 0,  0, 1, 64'h0,    1,  64'h10,   1, 0);
    cyc("jmp_flush",   0, 0, 0, 0,  0, 0, 64'h0,    1,  64'h0,    0, 0);
    cyc("prio_at0",    0, 0, 0, 1,  5, 1, 64'h103,  1,  64'h0,    1, 0);
    cyc("prio_flush",  0, 0, 0, 1,  3, 0, 64'h0,    1,  64'h100,  0, 1);
    cyc("reflush",     0, 0, 0, 0,  0, 0, 64'h0,    1,  64'h10C,  0, 1);
    cyc("run10c",      0, 0, 0, 0,  0, 0, 64'h0,    1,  64'h10C,  1, 1);
    cyc("halt_req",    0, 0, 1, 0,  0, 1, 64'h200,  1,  64'h110,  1, 1);
    cyc("halted",      0, 0, 0, 1,  1, 1, 64'h300,  1,  64'h110,  0, 1);
    cyc("halt_rst",    1, 0, 0, 0,  0, 0, 64'h0,    1,  64'h110,  0, 1);
    cyc("rst_over",    1, 1, 1, 1,  7, 1, 64'h3,    1,  64'h0,    0, 0);
    cyc("boot2",       0, 0, 0, 0,  0, 0, 64'h0,    1,  64'h0,    0, 0);
    cyc("run0b",       0, 0, 0, 0,  0, 0, 64'h0,    1,  64'h0,    1, 0);
    cyc("rst_mid_br",  1, 0, 0, 1,  4, 0, 64'h0,    1,  64'h4,    0, 0);
    cyc("boot3",       0, 0, 0, 0,  0, 0, 64'h0,    1,  64'h0,    0, 0);
    cyc("br_stall",    0, 1, 0, 1, 10, 0, 64'h0,    0,  64'h0,    0, 0);
    cyc("bs_flush",    0, 0, 0, 0,  0, 0, 64'h0,    1,  64'h28,   0, 0);
    cyc("bs_run",      0, 0, 0, 0,  0, 0, 64'h0,    1,  64'h28,   1, 0);

    // 8-bit instance: wrap, halt, reset, and modular branch arithmetic.
    cur_sel = 1'b1;
    cyc("w_reset",     1, 0, 0, 0,  0, 0, 64'h0,    1,  64'hF0,   0, 0);
    cyc("w_boot",      0, 0, 0, 0,  0, 0, 64'h0,    1,  64'hF0,   0, 0);
    cyc("w_f0",        0, 0, 0, 0,  0, 0, 64'h0,    1,  64'hF0,   1, 0);
    cyc("w_f4",        0, 0, 0, 0,  0, 0, 64'h0,    1,  64'hF4,   1, 0);
    cyc("w_f8",        0, 0, 0, 0,  0, 0, 64'h0,    1,  64'hF8,   1, 0);
    cyc("w_fc",        0, 0, 0, 0,  0, 0, 64'h0,    1,  64'hFC,   1, 0);
    cyc("w_wrap",      0, 0, 1, 0,  0, 0, 64'h0,    1,  64'h00,   1, 0);
    cyc("w_halt_a",    0, 0, 0, 0,  0, 0, 64'h0,    1,  64'h00,   0, 0);
    cyc("w_halt_b",    0, 0, 0, 1,  2, 0, 64'h0,    1,  64'h00,   0, 0);
    cyc("w_halt_rst",  1, 0, 0, 0,  0, 0, 64'h0,    1,  64'h00,   0, 0);
    cyc("w_boot2",     0, 0, 0, 0,  0, 0, 64'h0,    1,  64'hF0,   0, 0);
    cyc("w_br_neg",    0, 0, 0, 1,-61, 0, 64'h0,    1,  64'hF0,   1, 0);
    cyc("w_br_flush",  0, 0, 0, 0,  0, 0, 64'h0,    1,  64'hFC,   0, 0);
    cyc("w_br_run",    0, 0, 0, 0,  0, 0, 64'h0,    1,  64'hFC,   1, 0);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d expectations left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 64: PC and target width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 0: PC value loaded on reset, word-aligned.
REQ-003 SHALL have parameter OFF_W, default 26: width of the signed branch offset, in instructions.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port stall, input, 1: hold PC; no advance.
REQ-007 SHALL have port halt, input, 1: enter HALT state.
REQ-008 SHALL have port br_taken, input, 1: PC-relative redirect request (B / taken CBZ).
REQ-009 SHALL have port br_offset, input, OFF_W: signed instruction offset.
REQ-010 SHALL have port reg_jump, input, 1: absolute redirect request (BR).
REQ-011 SHALL have port jump_target, input, ADDR_W: absolute byte target.
REQ-012 SHALL have port fetch_ready, input, 1: instruction memory accepts the current fetch.
REQ-013 SHALL have port pc, output, ADDR_W: current fetch address.
REQ-014 SHALL have port pc_plus4, output, ADDR_W: pc+4, combinational, for BL link.
REQ-015 SHALL have port fetch_valid, output, 1: pc is a valid fetch request.
REQ-016 SHALL have port misalign_err, output, 1: sticky flag for a non-word-aligned jump_target.

Function
REQ-017 SHALL implement the states BOOT, RUN, FLUSH and HALT.
REQ-018 BOOT SHALL last exactly one cycle after reset deasserts, with fetch_valid=0, then go to RUN.
REQ-019 RUN SHALL drive fetch_valid=1 unless stall=1.
REQ-020 The PC SHALL advance by 4 only on a cycle with fetch_valid & fetch_ready & !stall.
REQ-021 Redirect priority per cycle SHALL be: reset > halt > reg_jump > br_taken > stall > increment.
REQ-022 A redirect SHALL be accepted in RUN or FLUSH regardless of fetch_ready or stall.
REQ-023 On an accepted redirect, the PC SHALL load the target on the next edge and the state SHALL go to FLUSH.
REQ-024 The br_taken target SHALL be pc + (sign-extended br_offset << 2), computed modulo 2^ADDR_W.
REQ-025 The reg_jump target SHALL be jump_target with bits [1:0] forced to 0.
REQ-026 If jump_target[1:0] != 0 on an accepted reg_jump, misalign_err SHALL set and hold until reset.
REQ-027 FLUSH SHALL drive fetch_valid=0 for one cycle (squash bubble), then return to RUN; a redirect during FLUSH SHALL reload the PC and stay in FLUSH.
REQ-028 Increment SHALL wrap from 2^ADDR_W-4 to 0 with no flag.
REQ-029 HALT SHALL drive fetch_valid=0 and freeze the PC; only reset SHALL leave HALT.
REQ-030 The PC SHALL be held with fetch_valid=1 when fetch_ready=0 (request stable until accepted).
REQ-031 When br_taken and reg_jump assert together, reg_jump SHALL win and br_offset SHALL be ignored.

Reset
REQ-032 While reset=1, pc SHALL be RESET_VEC, state SHALL be BOOT, fetch_valid SHALL be 0, and misalign_err SHALL be 0.
REQ-033 Reset asserted mid-redirect, mid-stall or in HALT SHALL override all inputs on that edge.

Structure
REQ-034 The state encoding and the INST_BYTES=4 constant SHALL live in shared package legv8_pkg.
REQ-035 The target adder (sign-extend, shift, add) SHALL be sub-module pc_target_adder; the FSM and PC register SHALL remain in pc_sequencer.

Verification
REQ-036 Reset then free run (RESET_VEC=0, fetch_ready=1): BOOT for 1 cycle, then pc = 0, 4, 8, 12 on consecutive cycles.
REQ-037 Backpressure: fetch_ready=0 for 3 cycles at pc=8: pc holds at 8 with fetch_valid=1, then steps to 12.
REQ-038 Branch: br_taken with br_offset=-2 at pc=16: next pc=8, FLUSH for 1 cycle with fetch_valid=0, then pc=12.
REQ-039 Priority and misalign: reg_jump (jump_target=0x103) and br_taken together at pc=0: next pc=0x100 and misalign_err=1 (sticky).
REQ-040 Wrap and halt, ADDR_W=8: pc=0xFC advances to 0x00; halt then freezes pc with fetch_valid=0 until reset restores RESET_VEC.
